// File: rtl/rank_order_scheduler.sv
// rtl/rank_order_scheduler.sv - rank-order pixel index sequencer feeding aer_in
// Optional feature macro: RANK_SKIP_ZERO_EN (zero-valued pixels are never emitted).
module rank_order_scheduler #(
  parameter int IMAGE_SIZE      = 256,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_MAX_VALUE = 255,
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       PIX_WR_EN,
  input  logic [IMAGE_SIZE_BITS-1:0] PIX_WR_ADDR,
  input  logic [PIXEL_BITS-1:0]      PIX_WR_DATA,
  input  logic                       START,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [IMAGE_SIZE_BITS:0]   EMIT_CNT,
  output logic [9:0]                 NEXT_INDEX,
  output logic                       FOUND_NEXT_INDEX,
  input  logic                       AERIN_CTRL_BUSY
);

  localparam int LEVEL_BITS = $clog2(PIXEL_MAX_VALUE + 1);
  localparam logic [LEVEL_BITS-1:0]      LEVEL_TOP = LEVEL_BITS'(PIXEL_MAX_VALUE);
`ifdef RANK_SKIP_ZERO_EN
  localparam logic [LEVEL_BITS-1:0]      LEVEL_LOW = LEVEL_BITS'(1);
`else
  localparam logic [LEVEL_BITS-1:0]      LEVEL_LOW = '0;
`endif
  localparam logic [IMAGE_SIZE_BITS-1:0] LAST_ADDR = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);
  localparam logic [IMAGE_SIZE_BITS:0]   SIZE_W    = (IMAGE_SIZE_BITS + 1)'(IMAGE_SIZE);

  typedef enum logic [2:0] {IDLE, SCAN, WAIT_BUSY, WAIT_FREE, FIN} state_t;

  logic [PIXEL_BITS-1:0]      pix_buf_q [IMAGE_SIZE];

  state_t                     state_q, state_d;
  logic [IMAGE_SIZE_BITS-1:0] scan_addr_q, scan_addr_d;
  logic [LEVEL_BITS-1:0]      level_q, level_d;
  logic [IMAGE_SIZE_BITS:0]   emit_cnt_q, emit_cnt_d;
  logic [9:0]                 next_index_q, next_index_d;
  logic                       found_q, found_d;
  logic                       done_q, done_d;
  logic                       busy_q, busy_d;

  logic [IMAGE_SIZE_BITS-1:0] adv_addr;
  logic [LEVEL_BITS-1:0]      adv_level;
  logic                       adv_fin;
  logic                       pix_match;
  logic [IMAGE_SIZE_BITS:0]   emit_target;

  // Buffer is only writable while idle so an in-flight emission sees a stable image.
  always_ff @(posedge CLK) begin
    if (PIX_WR_EN && state_q == IDLE && {1'b0, PIX_WR_ADDR} < SIZE_W)
      pix_buf_q[PIX_WR_ADDR] <= PIX_WR_DATA;
  end

`ifdef RANK_SKIP_ZERO_EN
  always_comb begin
    emit_target = '0;
    for (int i = 0; i < IMAGE_SIZE; i++)
      emit_target = emit_target + {{IMAGE_SIZE_BITS{1'b0}}, pix_buf_q[i] != '0};
  end
`else
  assign emit_target = SIZE_W;
`endif

  assign pix_match = (32'(pix_buf_q[scan_addr_q]) == 32'(level_q));

  // Scan position step: walk addresses, dropping one level on each address wrap.
  always_comb begin
    adv_addr  = scan_addr_q + 1'b1;
    adv_level = level_q;
    adv_fin   = 1'b0;
    if (scan_addr_q == LAST_ADDR) begin
      adv_addr = '0;
      if (level_q == LEVEL_LOW)
        adv_fin = 1'b1;
      else
        adv_level = level_q - 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    scan_addr_d  = scan_addr_q;
    level_d      = level_q;
    emit_cnt_d   = emit_cnt_q;
    next_index_d = next_index_q;
    found_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d     = SCAN;
          scan_addr_d = '0;
          level_d     = LEVEL_TOP;
          emit_cnt_d  = '0;
        end
      end
      SCAN: begin
        if (pix_match) begin
          next_index_d = 10'(scan_addr_q);
          found_d      = 1'b1;
          emit_cnt_d   = emit_cnt_q + 1'b1;
          state_d      = WAIT_BUSY;
        end else begin
          scan_addr_d = adv_addr;
          level_d     = adv_level;
          if (adv_fin)
            state_d = FIN;
        end
      end
      WAIT_BUSY: begin
        if (AERIN_CTRL_BUSY)
          state_d = WAIT_FREE;
      end
      WAIT_FREE: begin
        if (!AERIN_CTRL_BUSY) begin
          if (emit_cnt_q == emit_target || adv_fin) begin
            state_d = FIN;
          end else begin
            state_d     = SCAN;
            scan_addr_d = adv_addr;
            level_d     = adv_level;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      scan_addr_q  <= '0;
      level_q      <= LEVEL_TOP;
      emit_cnt_q   <= '0;
      next_index_q <= '0;
      found_q      <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_addr_q  <= scan_addr_d;
      level_q      <= level_d;
      emit_cnt_q   <= emit_cnt_d;
      next_index_q <= next_index_d;
      found_q      <= found_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign BUSY             = busy_q;
  assign DONE             = done_q;
  assign EMIT_CNT         = emit_cnt_q;
  assign NEXT_INDEX       = next_index_q;
  assign FOUND_NEXT_INDEX = found_q;

endmodule

// File: tb/tb_rank_order_scheduler.sv
// tb/tb_rank_order_scheduler.sv - bench for rank_order_scheduler (4 pixels, levels 0..3)
module tb_rank_order_scheduler;

  localparam int NPIX = 4;
  localparam int MAXV = 3;
`ifdef RANK_SKIP_ZERO_EN
  localparam int LOWV = 1;
`else
  localparam int LOWV = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PIX_WR_EN = 1'b0;
  logic [1:0] PIX_WR_ADDR = '0;
  logic [1:0] PIX_WR_DATA = '0;
  logic       START = 1'b0;
  logic       BUSY;
  logic       DONE;
  logic [2:0] EMIT_CNT;
  logic [9:0] NEXT_INDEX;
  logic       FOUND_NEXT_INDEX;
  logic       AERIN_CTRL_BUSY = 1'b0;

  rank_order_scheduler #(
    .IMAGE_SIZE      (NPIX),
    .PIXEL_MAX_VALUE (MAXV)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .PIX_WR_EN        (PIX_WR_EN),
    .PIX_WR_ADDR      (PIX_WR_ADDR),
    .PIX_WR_DATA      (PIX_WR_DATA),
    .START            (START),
    .BUSY             (BUSY),
    .DONE             (DONE),
    .EMIT_CNT         (EMIT_CNT),
    .NEXT_INDEX       (NEXT_INDEX),
    .FOUND_NEXT_INDEX (FOUND_NEXT_INDEX),
    .AERIN_CTRL_BUSY  (AERIN_CTRL_BUSY)
  );

  always #5 CLK = ~CLK;

  int   n_pass = 0;
  int   n_total = 0;
  logic [1:0] img [NPIX];
  int   exp_q[$];
  int   got[$];
  int   done_cnt;
  int   proto_err;
  int   busy_hold = 3;
  int   aer_cnt = 0;
  bit   aer_pend = 0;
  bit   outstanding = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference order: every level from the top down, indices ascending within a level.
  task automatic build_exp();
    exp_q.delete();
    for (int lv = MAXV; lv >= LOWV; lv--)
      for (int i = 0; i < NPIX; i++)
        if (int'(img[i]) == lv) exp_q.push_back(i);
  endtask

  // One cycle: sample outputs at the falling edge, then play the aer_in responder.
  task automatic tick();
    @(negedge CLK);
    if (DONE) done_cnt++;
    if (aer_cnt > 0) begin
      aer_cnt--;
      if (aer_cnt == 0) begin
        AERIN_CTRL_BUSY = 1'b0;
        outstanding = 0;
      end
    end else if (aer_pend) begin
      aer_pend = 0;
      AERIN_CTRL_BUSY = 1'b1;
      aer_cnt = busy_hold;
    end
    if (FOUND_NEXT_INDEX) begin
      if (outstanding) proto_err++;
      outstanding = 1;
      aer_pend = 1;
      got.push_back(int'(NEXT_INDEX));
    end
  endtask

  task automatic load_img();
    for (int i = 0; i < NPIX; i++) begin
      PIX_WR_EN = 1'b1;
      PIX_WR_ADDR = 2'(i);
      PIX_WR_DATA = img[i];
      tick();
    end
    PIX_WR_EN = 1'b0;
  endtask

  task automatic run_image(input bit inject, input string tag);
    got.delete();
    done_cnt = 0;
    proto_err = 0;
    build_exp();
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int c = 0; c < 600 && done_cnt == 0; c++) begin
      tick();
      if (inject && done_cnt == 0) begin
        PIX_WR_EN = 1'($urandom_range(0, 1));
        PIX_WR_ADDR = 2'($urandom_range(0, 3));
        PIX_WR_DATA = 2'($urandom_range(0, 3));
        START = 1'($urandom_range(0, 1));
      end else begin
        PIX_WR_EN = 1'b0;
        START = 1'b0;
      end
    end
    PIX_WR_EN = 1'b0;
    START = 1'b0;
    check({tag, ".emit_cnt"}, int'(EMIT_CNT), exp_q.size());
    tick();
    check({tag, ".done_once"}, done_cnt, 1);
    check({tag, ".busy_after"}, int'(BUSY), 0);
    check({tag, ".n_found"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s.idx%0d", tag, i), got[i], exp_q[i]);
    check({tag, ".protocol"}, proto_err, 0);
  endtask

  initial begin
    tick();
    tick();
    check("rst.busy", int'(BUSY), 0);
    check("rst.done", int'(DONE), 0);
    check("rst.found", int'(FOUND_NEXT_INDEX), 0);
    check("rst.next_index", int'(NEXT_INDEX), 0);
    check("rst.emit_cnt", int'(EMIT_CNT), 0);
    RST = 1'b0;
    tick();

    img = '{2'd2, 2'd3, 2'd0, 2'd1};
    load_img();
    run_image(0, "mixed");

    img = '{2'd1, 2'd1, 2'd1, 2'd1};
    load_img();
    run_image(0, "equal");

    busy_hold = 20;
    img = '{2'd2, 2'd3, 2'd0, 2'd1};
    load_img();
    run_image(0, "long_busy");
    busy_hold = 3;

    img = '{2'd0, 2'd3, 2'd3, 2'd2};
    load_img();
    run_image(1, "inject");
    run_image(0, "inject_rerun");

    // Reset while the scheduler is waiting for aer_in to go idle.
    img = '{2'd2, 2'd3, 2'd0, 2'd1};
    load_img();
    got.delete();
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int c = 0; c < 100 && !AERIN_CTRL_BUSY; c++) tick();
    check("rst_mid.aer_busy_seen", int'(AERIN_CTRL_BUSY), 1);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    AERIN_CTRL_BUSY = 1'b0;
    aer_cnt = 0;
    aer_pend = 0;
    outstanding = 0;
    check("rst_mid.busy", int'(BUSY), 0);
    check("rst_mid.found", int'(FOUND_NEXT_INDEX), 0);
    check("rst_mid.emit_cnt", int'(EMIT_CNT), 0);
    got.delete();
    for (int c = 0; c < 6; c++) tick();
    check("rst_mid.quiet", got.size(), 0);
    run_image(0, "after_rst");

    img = '{2'd0, 2'd2, 2'd0, 2'd0};
    load_img();
    run_image(0, "single_nonzero");

    img = '{2'd0, 2'd0, 2'd0, 2'd0};
    load_img();
    run_image(0, "all_zero");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NPIX; i++) img[i] = 2'($urandom_range(0, 3));
      busy_hold = $urandom_range(1, 5);
      load_img();
      run_image(r[0], $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
